gpio_byte_packer: RTL and testbench
===================================

Name: gpio_byte_packer

Overview:
- Upstream feeder for the 4-byte max-reduction stage.
- Collects a serial byte stream from the GPIO input path, with a valid/ready handshake, and packs 4 consecutive bytes into one 32-bit word.
- Hands the word to the downstream consumer through a one-entry registered output slot with its own valid/ready handshake.
- Supports a flush that emits a partially filled word, zero-padded.

Parameters:
- DATA_W, 8, byte lane width in bits.
- N_BYTES, 4, bytes per output word; word width WORD_W = DATA_W*N_BYTES.
- CNT_W, 3, width of byte-count output; must satisfy 2**CNT_W > N_BYTES.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  DATA_W  byte from GPIO input path.
- in_ready  output  1  packer accepts the byte this cycle.
- flush  input  1  single-cycle request to emit the current partial word.
- out_valid  output  1  out_data/out_count hold a word.
- out_data  output  WORD_W  packed word; first byte at [WORD_W-1 -: DATA_W], i.e. [31:24].
- out_count  output  CNT_W  number of real bytes in out_data (1..N_BYTES).
- out_ready  input  1  downstream consumes the word this cycle.
- busy  output  1  accumulator non-empty or flush pending.

Behaviour:
- Reset (async, any time, including mid-word): accumulator=0, idx=0, flush_pend=0, out_valid=0, out_data=0, out_count=0, busy=0. A partial word is discarded and never emitted.
- Accept: byte accepted when in_valid && in_ready. It is written to lane idx, lane 0 = MSBs, and idx increments.
- Slot free: slot_free = !out_valid || out_ready. A word accepted and a word drained on the same edge is legal.
- in_ready = !flush_pend && (idx != N_BYTES-1 || slot_free). The first N_BYTES-1 bytes always fit; the closing byte needs a free slot.
- Word completion: when the accepted byte fills lane N_BYTES-1:
  - On that edge: out_data = full word, out_count = N_BYTES, out_valid = 1, accumulator cleared, idx = 0.
  - Latency is 1 cycle from last-byte handshake to out_valid.
  - Sustained throughput is 1 byte/cycle while out_ready = 1.
- Flush sampled with idx_eff > 0, where idx_eff = idx plus 1 if a byte is accepted the same cycle:
  - The same-cycle byte is included first.
  - If slot_free: emit on that edge with out_count = idx_eff; unfilled low lanes are 0; accumulator and idx clear.
  - Otherwise set flush_pend. While pending, in_ready = 0; emit on the first cycle slot_free = 1, then clear flush_pend.
- Flush boundary cases:
  - Flush with idx_eff = 0: ignored, no word emitted.
  - Flush in the same cycle as the closing byte of a full word: a normal full word is emitted; the flush is then a no-op.
  - Flush while flush_pend = 1: ignored (already pending).
- Output slot:
  - out_data/out_count stay stable while out_valid && !out_ready.
  - out_valid falls on the edge after a handshake unless a new word loads on the same edge.
- busy = (idx != 0) || flush_pend.
- FSM, two states:
  - ACC (flush_pend = 0) -> FLUSH_WAIT on a flush that cannot emit because the slot is occupied.
  - FLUSH_WAIT -> ACC when the slot frees and the word is emitted.
- idx range 0..N_BYTES-1 and wraps to 0 only on word completion or flush. No overflow is possible because in_ready gates acceptance.

Decomposition:
- Shared package: DATA_W/N_BYTES defaults, WORD_W, CNT_W derivation, and ACC/FLUSH_WAIT state encoding.
- One sub-module: gpio_byte_packer_slot, the one-entry valid/ready output register (load, hold, drain, async reset).
- Lane write, index counter, and flush logic stay in the top module.

Test Plan:
- Back-to-back bytes 0xA1,0xB2,0xC3,0xD4 with out_ready=1 -> one cycle after the 4th handshake: out_valid=1, out_data=0xA1B2C3D4, out_count=4; in_ready stays 1 throughout.
- 8 consecutive bytes 0x01..0x08 with out_ready=0 until cycle 10 -> first word 0x01020304 held stable; in_ready=0 when byte 0x08 is offered; after drain, second word = 0x05060708.
- Bytes 0x11,0x22 then flush with slot free -> out_data=0x11220000, out_count=2, busy=0 the next cycle.
- Slot occupied (out_ready=0), byte 0x33 plus flush in the same cycle -> flush_pend=1, in_ready=0; release out_ready -> next word = 0x33000000, out_count=1.
- Flush with empty accumulator -> out_valid remains 0; flush on the 4th byte 0x44 after 0x10,0x20,0x30 -> single word 0x10203044, count 4.
- Assert rst asynchronously after 2 bytes and mid-output-hold -> out_valid, idx, busy drop immediately; next bytes 0x55..0x88 yield 0x55667788 with no stale data.

Source files
------------

// File: rtl/gpio_byte_packer_pkg.sv
// Shared defaults, derived widths and packer state encoding.
package gpio_byte_packer_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int N_BYTES_DEF = 4;
    localparam int CNT_W_DEF   = 3;
    localparam int WORD_W_DEF  = DATA_W_DEF * N_BYTES_DEF;

    // ACC: collecting bytes; FLUSH_WAIT: partial word waiting for the slot.
    typedef enum logic {
        ACC        = 1'b0,
        FLUSH_WAIT = 1'b1
    } pack_state_t;

    // Smallest count width able to hold the value n (n itself, not n-1).
    function automatic int calc_cnt_w(input int n);
        int w;
        w = 1;
        while ((1 << w) <= n) w++;
        return w;
    endfunction

endpackage

// File: rtl/gpio_byte_packer_slot.sv
// One-entry registered output slot with a valid/ready handshake.
module gpio_byte_packer_slot #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count
);

    // Load wins over drain so a word can be consumed and replaced on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_count <= load_count;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gpio_byte_packer.sv
// Packs a serial byte stream into words, first byte in the MSB lane,
// with a flush that emits a zero-padded partial word.
module gpio_byte_packer
    import gpio_byte_packer_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int N_BYTES = N_BYTES_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    input  logic                        flush,
    output logic                        out_valid,
    output logic [DATA_W*N_BYTES-1:0]   out_data,
    output logic [CNT_W-1:0]            out_count,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam int               WORD_W = DATA_W * N_BYTES;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(N_BYTES - 1);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(N_BYTES);

    pack_state_t       state;
    logic [WORD_W-1:0] acc;
    logic [CNT_W-1:0]  idx;

    logic              slot_free;
    logic              accept;
    logic              complete;
    logic              flush_req;
    logic [WORD_W-1:0] acc_wr;
    logic [CNT_W-1:0]  idx_eff;
    logic              load;
    logic [WORD_W-1:0] load_data;
    logic [CNT_W-1:0]  load_count;

    // Handshake, lane write and emit decision for this cycle.
    always_comb begin
        slot_free = !out_valid || out_ready;
        // Only the closing byte needs the slot; nothing enters while a flush waits.
        in_ready  = (state == ACC) && ((idx != LAST) || slot_free);
        accept    = in_valid && in_ready;

        acc_wr = acc;
        for (int i = 0; i < N_BYTES; i++) begin
            if (accept && (idx == CNT_W'(i)))
                acc_wr[WORD_W-1-i*DATA_W -: DATA_W] = in_data;
        end
        idx_eff  = idx + CNT_W'(accept);
        complete = accept && (idx == LAST);

        // A flush on the closing byte is absorbed by the normal full-word emit.
        flush_req = flush && (state == ACC) && (idx_eff != '0) && !complete;

        load       = 1'b0;
        load_data  = acc_wr;
        load_count = idx_eff;
        if (complete) begin
            load       = 1'b1;
            load_count = FULL;
        end else if ((state == FLUSH_WAIT) && slot_free) begin
            load       = 1'b1;
            load_data  = acc;
            load_count = idx;
        end else if (flush_req && slot_free) begin
            load = 1'b1;
        end
    end

    // Accumulator, byte index and flush-pending state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
            acc   <= '0;
            idx   <= '0;
        end else if (load) begin
            state <= ACC;
            acc   <= '0;
            idx   <= '0;
        end else if (flush_req) begin
            state <= FLUSH_WAIT;
            acc   <= acc_wr;
            idx   <= idx_eff;
        end else begin
            acc   <= acc_wr;
            idx   <= idx_eff;
        end
    end

    assign busy = (idx != '0) || (state == FLUSH_WAIT);

    gpio_byte_packer_slot #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (load_data),
        .load_count (load_count),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_count  (out_count)
    );

endmodule

// File: tb/tb_gpio_byte_packer.sv
// Directed bench for gpio_byte_packer with a cycle-level reference model.
module tb_gpio_byte_packer;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_count;
    logic        out_ready = 1'b0;
    logic        busy;

    int n_checks = 0;
    int n_errs   = 0;

    gpio_byte_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mb[$];
    bit          m_pend;
    bit          m_valid;
    logic [31:0] m_data;
    logic [2:0]  m_count;

    function automatic logic [31:0] pack_bytes(input logic [7:0] q[$]);
        logic [31:0] w;
        w = '0;
        foreach (q[i]) w[31-8*i -: 8] = q[i];
        return w;
    endfunction

    // Mid-cycle: compare DUT against model, then advance model across the next edge.
    always @(negedge clk) begin
        bit slot_free, exp_rdy, emit;
        if (rst) begin
            mb.delete();
            m_pend = 0; m_valid = 0; m_data = '0; m_count = '0;
            chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_busy", {31'b0, busy}, 32'd0);
        end else begin
            slot_free = !m_valid || out_ready;
            exp_rdy   = !m_pend && (mb.size() != NB-1 || slot_free);
            chk("m_in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
            chk("m_busy", {31'b0, busy}, {31'b0, (mb.size() != 0 || m_pend)});
            chk("m_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            if (m_valid) begin
                chk("m_out_data", out_data, m_data);
                chk("m_out_count", {29'b0, out_count}, {29'b0, m_count});
            end
            if (in_valid && exp_rdy) mb.push_back(in_data);
            emit = 0;
            if (mb.size() == NB) emit = 1;
            else if (m_pend) begin
                if (slot_free) begin emit = 1; m_pend = 0; end
            end else if (flush && mb.size() > 0) begin
                if (slot_free) emit = 1; else m_pend = 1;
            end
            if (emit) begin
                m_valid = 1;
                m_data  = pack_bytes(mb);
                m_count = 3'(mb.size());
                mb.delete();
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic push(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("push_timeout", 32'd1, 32'd0);
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_word(input string name, input logic [31:0] d, input logic [2:0] c);
        chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({name, "_data"}, out_data, d);
        chk({name, "_count"}, {29'b0, out_count}, {29'b0, c});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) step();
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_out_count", {29'b0, out_count}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        step();

        // Back-to-back full word, slot always draining
        out_ready = 1'b1;
        push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
        chk_word("t1", 32'hA1B2C3D4, 3'd4);
        step();
        chk("t1_drained", {31'b0, out_valid}, 32'd0);

        // Backpressure: second word's closing byte waits on the slot
        out_ready = 1'b0;
        for (int b = 1; b <= 7; b++) push(8'(b));
        in_valid = 1'b1; in_data = 8'h08;
        @(negedge clk);
        chk("t2_closing_blocked", {31'b0, in_ready}, 32'd0);
        chk("t2_hold_data", out_data, 32'h01020304);
        step();
        chk("t2_hold_data2", out_data, 32'h01020304);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t2_closing_open", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk_word("t2", 32'h05060708, 3'd4);
        step();

        // Partial flush with a free slot
        push(8'h11); push(8'h22);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_word("t3", 32'h11220000, 3'd2);
        chk("t3_busy", {31'b0, busy}, 32'd0);
        step();

        // Flush behind an occupied slot goes pending
        out_ready = 1'b0;
        push(8'h91); push(8'h92); push(8'h93); push(8'h94);
        in_valid = 1'b1; in_data = 8'h33; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("t4_pend_in_ready", {31'b0, in_ready}, 32'd0);
        chk("t4_pend_busy", {31'b0, busy}, 32'd1);
        step();
        chk("t4_hold", out_data, 32'h91929394);
        out_ready = 1'b1;
        step();
        chk_word("t4", 32'h33000000, 3'd1);
        chk("t4_busy_clear", {31'b0, busy}, 32'd0);
        step();

        // Empty flush ignored; flush on closing byte is a plain full word
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_empty_flush", {31'b0, out_valid}, 32'd0);
        push(8'h10); push(8'h20); push(8'h30);
        in_valid = 1'b1; in_data = 8'h44; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk_word("t5", 32'h10203044, 3'd4);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        step();
        chk("t5_no_extra", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset mid-word and mid-hold
        out_ready = 1'b0;
        push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
        push(8'hF1); push(8'hF2);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_async_busy", {31'b0, busy}, 32'd0);
        chk("t6_async_data", out_data, 32'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        chk_word("t6", 32'h55667788, 3'd4);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
